emesh_wr_buffer: RTL and testbench

- Elastic write-packet buffer directly downstream of the AXI slave (esaxi) write channel.
- Consumes the slave's 104-bit eMesh write packets (wr_access/wr_packet) and drives its wr_wait.
- Presents buffered packets first-word-fall-through to the eMesh transmit path with wait-based flow control.
- Drops non-write packets and flags them in a sticky error bit.

---
 rtl/emesh_pkg.sv | 11 +
 rtl/emesh_fifo_core.sv | 34 +++
 rtl/emesh_wr_buffer.sv | 60 ++++++
 tb/tb_emesh_wr_buffer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/emesh_pkg.sv
// emesh_pkg: eMesh packet width, field offsets and packet type shared by the write buffer
package emesh_pkg;
  localparam int PW        = 104;
  localparam int WRITE_BIT = 0;
  localparam int DMODE_LSB = 1;
  localparam int CTRL_LSB  = 3;
  localparam int DST_LSB   = 8;
  localparam int DATA_LSB  = 40;
  localparam int SRC_LSB   = 72;
  typedef logic [PW-1:0] emesh_packet_t;
endpackage

// File: rtl/emesh_fifo_core.sv
// emesh_fifo_core: FWFT packet storage with pointers and occupancy count (push/pop/full/empty/count)
module emesh_fifo_core import emesh_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  emesh_packet_t wdata,
  output emesh_packet_t rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  emesh_packet_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
    end
  assign rdata = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/emesh_wr_buffer.sv
// emesh_wr_buffer: elastic FWFT write-packet buffer between esaxi write channel and eMesh tx; drops non-writes
// Ports: clk, rst (async high), in_access/in_packet/in_wait (slave side), out_access/out_packet/out_wait (tx side),
//   err_drop (sticky) / err_clr, level (occupancy). Optional stat_pkts/stat_stall with EMESH_WRBUF_STATS_EN.
module emesh_wr_buffer import emesh_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_access,
  input  emesh_packet_t in_packet,
  output logic          in_wait,
  output logic          out_access,
  output emesh_packet_t out_packet,
  input  logic          out_wait,
  output logic          err_drop,
  input  logic          err_clr,
  output logic [AW:0]   level
`ifdef EMESH_WRBUF_STATS_EN
  ,output logic [31:0]  stat_pkts,
  output logic [31:0]   stat_stall
`endif
);
  logic full, empty, accept, push, drop, pop;
  // in_wait comes from registered count only, so a pop while full does not free a slot until next cycle
  assign in_wait    = full;
  assign out_access = ~empty;
  assign accept     = in_access & ~in_wait;
  assign push       = accept & in_packet[WRITE_BIT];
  assign drop       = accept & ~in_packet[WRITE_BIT];
  assign pop        = out_access & ~out_wait;
  emesh_fifo_core #(.DEPTH(DEPTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_packet),
    .rdata (out_packet),
    .full  (full),
    .empty (empty),
    .count (level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) err_drop <= 1'b0;
    else if (drop) err_drop <= 1'b1;
    else if (err_clr) err_drop <= 1'b0;
`ifdef EMESH_WRBUF_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_pkts  <= '0;
      stat_stall <= '0;
    end else if (err_clr) begin
      stat_pkts  <= '0;
      stat_stall <= '0;
    end else begin
      stat_pkts  <= pop ? stat_pkts + 1'b1 : stat_pkts;
      stat_stall <= (in_access & in_wait & (stat_stall != '1)) ? stat_stall + 1'b1 : stat_stall;
    end
`endif
endmodule

// File: tb/tb_emesh_wr_buffer.sv
// tb_emesh_wr_buffer: directed plus random stimulus against a queue model, decoupled scoreboard monitor
module tb_emesh_wr_buffer;
  import emesh_pkg::*;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  logic clk = 1'b0, rst = 1'b1, in_access = 1'b0, out_wait = 1'b0, err_clr = 1'b0;
  emesh_packet_t in_packet = '0, out_packet;
  logic in_wait, out_access, err_drop;
  logic [AW:0] level;
`ifdef EMESH_WRBUF_STATS_EN
  logic [31:0] stat_pkts, stat_stall;
  int unsigned mpkts = 0, mstall = 0;
`endif
  int n_chk = 0, n_fail = 0;
  int mcount = 0;
  bit merr = 0;
  emesh_packet_t sb[$];
  emesh_wr_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_access  (in_access),
    .in_packet  (in_packet),
    .in_wait    (in_wait),
    .out_access (out_access),
    .out_packet (out_packet),
    .out_wait   (out_wait),
    .err_drop   (err_drop),
    .err_clr    (err_clr),
    .level      (level)
`ifdef EMESH_WRBUF_STATS_EN
    ,.stat_pkts (stat_pkts),
    .stat_stall (stat_stall)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && out_access && !out_wait) begin
      if (sb.size() == 0) chk("out_access_unexpected", 128'(out_access), 128'(0));
      else chk("out_packet", 128'(out_packet), 128'(sb.pop_front()));
    end
  function automatic emesh_packet_t mk(input int d, input bit w);
    emesh_packet_t p = '0;
    p[DATA_LSB +: 32] = 32'(d);
    p[DST_LSB +: 32]  = 32'h8080_0000;
    p[DMODE_LSB +: 2] = 2'd2;
    p[WRITE_BIT]      = w;
    return p;
  endfunction
  task automatic step(input bit acc, input emesh_packet_t p, input bit ow, input bit clr);
    bit full, ok, drop, pop;
    @(posedge clk);
    #1;
    in_access = acc;
    in_packet = p;
    out_wait  = ow;
    err_clr   = clr;
    @(negedge clk);
    chk("level", 128'(level), 128'(mcount));
    chk("in_wait", 128'(in_wait), 128'(mcount == DEPTH));
    chk("out_access", 128'(out_access), 128'(mcount != 0));
    chk("err_drop", 128'(err_drop), 128'(merr));
`ifdef EMESH_WRBUF_STATS_EN
    chk("stat_pkts", 128'(stat_pkts), 128'(mpkts));
    chk("stat_stall", 128'(stat_stall), 128'(mstall));
`endif
    full = mcount == DEPTH;
    ok   = acc && !full && p[WRITE_BIT];
    drop = acc && !full && !p[WRITE_BIT];
    pop  = mcount != 0 && !ow;
    if (ok) sb.push_back(p);
    mcount = mcount + int'(ok) - int'(pop);
    merr = drop ? 1'b1 : clr ? 1'b0 : merr;
`ifdef EMESH_WRBUF_STATS_EN
    mpkts  = clr ? 0 : mpkts + 32'(pop);
    mstall = clr ? 0 : mstall + 32'(acc && full);
`endif
  endtask
  initial begin
    emesh_packet_t p;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_out_access", 128'(out_access), 128'(0));
    chk("rst_in_wait", 128'(in_wait), 128'(0));
    chk("rst_err_drop", 128'(err_drop), 128'(0));
    rst = 1'b0;
    step(1, {32'h0, 32'hDEAD_BEEF, 32'h8080_0000, 5'd0, 2'd2, 1'b1}, 0, 0);
    repeat (3) step(0, '0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, mk(i, 1), 1, 0);
    repeat (2) step(1, mk(8, 1), 1, 0);
    step(1, mk(8, 1), 0, 0);
    step(1, mk(8, 1), 1, 0);
    step(0, '0, 1, 0);
    repeat (12) step(0, '0, 0, 0);
    step(1, mk(9, 0), 0, 0);
    repeat (2) step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    step(1, mk(10, 0), 0, 1);
    repeat (2) step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, mk(20 + i, 1), 1, 0);
    step(0, '0, 1, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_access = 1'b0;
    #1;
    chk("async_rst_out_access", 128'(out_access), 128'(0));
    chk("async_rst_level", 128'(level), 128'(0));
    chk("async_rst_in_wait", 128'(in_wait), 128'(0));
    sb.delete();
    mcount = 0;
    merr = 0;
`ifdef EMESH_WRBUF_STATS_EN
    mpkts = 0;
    mstall = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    step(1, mk(30, 1), 0, 0);
    repeat (3) step(0, '0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      p[31:0]   = $urandom;
      p[63:32]  = $urandom;
      p[95:64]  = $urandom;
      p[103:96] = 8'($urandom);
      if ($urandom_range(9) == 0) p[WRITE_BIT] = 1'b0;
      else p[WRITE_BIT] = 1'b1;
      step($urandom_range(9) < 7, p, $urandom_range(9) < (i % 600 < 300 ? 6 : 2), $urandom_range(19) == 0);
    end
    repeat (12) step(0, '0, 0, 0);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
